ram_dual_port: RTL and testbench
================================

RAM_DUAL_PORT -- requirements
Module: ram_dual_port

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter AD, default 4, address width; depth is 2^AD words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have parameter RDW_MODE, default 0, same-address read-during-write policy; 0 = read-first (old data), 1 = write-first (new data).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_cs, input, 1, write-port chip select.
REQ-008 SHALL have port wr_en, input, 1, write enable; a write occurs only when wr_cs & wr_en.
REQ-009 SHALL have port wr_addr, input, AD, write address.
REQ-010 SHALL have port wr_be, input, DW/8, byte-lane write enables; bit i covers wr_data[8i+7:8i].
REQ-011 SHALL have port wr_data, input, DW, write data.
REQ-012 SHALL have port rd_cs, input, 1, read-port chip select.
REQ-013 SHALL have port rd_en, input, 1, read enable; a read is issued only when rd_cs & rd_en.
REQ-014 SHALL have port rd_addr, input, AD, read address.
REQ-015 SHALL have port rd_data, output, DW, registered read data.
REQ-016 SHALL have port rd_valid, output, 1, one-cycle pulse marking new rd_data.
REQ-017 SHALL have port collision, output, 1, one-cycle pulse aligned with rd_valid when that read hit a same-cycle write to the same address.

Function
REQ-018 SHALL write, at the clk edge where wr_cs & wr_en, only the byte lanes with wr_be set; the other lanes keep their contents; wr_be = 0 writes nothing.
REQ-019 SHALL capture a read issued at edge N, drive rd_data at edge N+RD_LAT-1+1 (RD_LAT=1: after edge N+1; RD_LAT=2: after edge N+2), and pulse rd_valid high for exactly that one cycle.
REQ-020 SHALL accept one read per cycle (fully pipelined); back-to-back reads produce back-to-back rd_valid pulses in issue order.
REQ-021 SHALL hold rd_data unchanged between rd_valid pulses.
REQ-022 SHALL flag a collision when a read and a write issue at the same edge with rd_addr == wr_addr and wr_be != 0.
REQ-023 SHALL return pre-write contents on all lanes for a collision when RDW_MODE=0.
REQ-024 SHALL return, for a collision when RDW_MODE=1, wr_data on lanes with wr_be set and pre-write contents on the other lanes.
REQ-025 SHALL not flag a collision when the read and write are issued in different cycles; such a read returns the memory contents at the read edge.
REQ-026 SHALL cover addresses 0 to 2^AD-1 with no aliasing; address 2^AD-1 is as valid as 0.
REQ-027 SHALL fail elaboration when DW%8 != 0 or RD_LAT is not 1 or 2.

Reset
REQ-028 SHALL clear rd_data, rd_valid, collision and every internal pipeline stage (data, valid and collision bits) to 0 immediately on assertion of rst_n = 0.
REQ-029 SHALL discard any read in flight at reset; no rd_valid pulse follows for it after release.
REQ-030 SHALL not initialise or modify memory contents on reset; contents written before reset remain readable after reset.
REQ-031 SHALL ignore reads and writes while rst_n = 0.

Structure
REQ-032 SHALL place the RDW_MODE encodings (RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1) and the legal RD_LAT values in shared package ram_pkg.
REQ-033 SHALL implement the optional second read stage as sub-module ram_rd_stage, carrying data, valid and collision bits, with reset, parameterised by DW.
REQ-034 SHALL write the storage array without reset so that synthesis infers block RAM.

Verification
REQ-035 SHALL cover byte-enable writes: DW=32; write 0xAABBCCDD to addr 3 with be=4'hF, then 0x11223344 with be=4'b0101 -> read of addr 3 returns 0xAA22CC44.
REQ-036 SHALL cover latency: for RD_LAT=1 and RD_LAT=2, read addr 5 (contents 0x5A) at edge N -> rd_valid high only in the cycle after edge N+1 or N+2 respectively, rd_data=0x5A.
REQ-037 SHALL cover collision: addr 7 holds 0x00, write 0xFF with be all ones and read addr 7 on the same edge -> collision=1; rd_data=0x00 for RDW_MODE=0 and 0xFF for RDW_MODE=1.
REQ-038 SHALL cover streaming: reads of addrs 0..15 on consecutive cycles -> 16 consecutive rd_valid pulses returning contents in order, including addr 15.
REQ-039 SHALL cover reset mid-read: issue a read, assert rst_n low before the data returns -> outputs are 0 at once, no rd_valid after release, and memory contents are intact.

Source files
------------

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared constants for the dual-port RAM slice: read-during-write policy
// encodings and the legal read-latency values, plus a small legality helper
// used when elaborating the top level.
// ---------------------------------------------------------------------------
package ram_pkg;

  // Same-address read-during-write policy encodings
  localparam int unsigned RDW_READ_FIRST  = 32'd0;
  localparam int unsigned RDW_WRITE_FIRST = 32'd1;

  // Legal read latencies (cycles)
  localparam int unsigned RD_LAT_ONE = 32'd1;
  localparam int unsigned RD_LAT_TWO = 32'd2;

  // True when the requested read latency is one the pipeline supports
  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat == RD_LAT_ONE) || (lat == RD_LAT_TWO);
  endfunction

  // True when the data width is a whole number of bytes between 8 and 64
  function automatic bit dw_legal(input int unsigned dw);
    return ((dw % 32'd8) == 32'd0) && (dw >= 32'd8) && (dw <= 32'd64);
  endfunction

endpackage

// File: rtl/ram_rd_stage.sv
// ---------------------------------------------------------------------------
// ram_rd_stage
// One extra registered stage of the read return path. Carries the read data,
// its valid bit and its collision flag. Data is only reloaded when a valid
// read passes through, so the output word holds between valid pulses.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid/in_collision    previous stage
//   out_data/out_valid/out_collision registered outputs
// ---------------------------------------------------------------------------
module ram_rd_stage #(
  parameter int unsigned DW = 32'd8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_collision,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_collision
);

  // Pipeline register: valid/collision every cycle, data only on a valid read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_collision <= 1'b0;
    end else begin
      out_valid     <= in_valid;
      out_collision <= in_collision;
      if (in_valid) begin
        out_data <= in_data;
      end else begin
        out_data <= out_data;
      end
    end
  end

endmodule

// File: rtl/ram_dual_port.sv
// ---------------------------------------------------------------------------
// ram_dual_port
// Simple dual-port RAM (one write port, one read port, single clock) with
// byte-lane write enables, 1- or 2-cycle fully pipelined reads, a selectable
// same-address read-during-write policy and a collision flag.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   wr_cs, wr_en, wr_addr, wr_be, wr_data   write port
//   rd_cs, rd_en, rd_addr              read request
//   rd_data, rd_valid, collision       registered read return
// Storage is never reset; only the read-return pipeline is.
// ---------------------------------------------------------------------------
module ram_dual_port
  import ram_pkg::*;
#(
  parameter int unsigned DW       = 32'd8,
  parameter int unsigned AD       = 32'd4,
  parameter int unsigned RD_LAT   = 32'd1,
  parameter int unsigned RDW_MODE = 32'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_cs,
  input  logic            wr_en,
  input  logic [AD-1:0]   wr_addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   wr_data,
  input  logic            rd_cs,
  input  logic            rd_en,
  input  logic [AD-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            collision
);

  localparam int unsigned NB    = DW / 32'd8;
  localparam int unsigned DEPTH = 32'd1 << AD;

  // Reject illegal configurations at elaboration time
  if (!dw_legal(DW)) begin : g_bad_dw
    $error("ram_dual_port: DW must be a multiple of 8 in 8..64");
  end
  if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
    $error("ram_dual_port: RD_LAT must be 1 or 2");
  end
  if (RDW_MODE > RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("ram_dual_port: RDW_MODE must be 0 or 1");
  end

  logic [DW-1:0] mem [DEPTH];

  logic          wr_fire;
  logic          rd_fire;
  logic          same_addr;
  logic [DW-1:0] old_word;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] s1_data;
  logic          s1_valid;
  logic          s1_collision;

  // Writes are gated by rst_n so nothing lands in the array during reset;
  // reads need no gate because the return pipeline is held in reset.
  assign wr_fire   = wr_cs & wr_en & rst_n;
  assign rd_fire   = rd_cs & rd_en;
  assign same_addr = rd_fire & wr_fire & (rd_addr == wr_addr) & (|wr_be);
  assign old_word  = mem[rd_addr];

  // Storage array: byte-lane writes, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_fire && wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read word: write-first forwards the lanes being written this edge
  always_comb begin
    rd_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (same_addr && (RDW_MODE == RDW_WRITE_FIRST) && wr_be[i]) begin
        rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end else begin
        rd_word[8*i +: 8] = old_word[8*i +: 8];
      end
    end
  end

  // First read stage: captures the addressed word on every issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data      <= '0;
      s1_valid     <= 1'b0;
      s1_collision <= 1'b0;
    end else begin
      s1_valid     <= rd_fire;
      s1_collision <= same_addr;
      if (rd_fire) begin
        s1_data <= rd_word;
      end else begin
        s1_data <= s1_data;
      end
    end
  end

  if (RD_LAT == RD_LAT_TWO) begin : g_lat2
    ram_rd_stage #(
      .DW (DW)
    ) u_rd_stage (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (s1_data),
      .in_valid      (s1_valid),
      .in_collision  (s1_collision),
      .out_data      (rd_data),
      .out_valid     (rd_valid),
      .out_collision (collision)
    );
  end else begin : g_lat1
    assign rd_data   = s1_data;
    assign rd_valid  = s1_valid;
    assign collision = s1_collision;
  end

endmodule

// File: tb/tb_ram_dual_port.sv
// ---------------------------------------------------------------------------
// tb_ram_dual_port
// Two instances share one stimulus stream:
//   u_rf : DW=32, RD_LAT=1, read-first
//   u_wf : DW=32, RD_LAT=2, write-first
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_ram_dual_port;

  logic        clk;
  logic        rst_n;
  logic        wr_cs;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_cs;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] rf_data;
  logic        rf_valid;
  logic        rf_coll;
  logic [31:0] wf_data;
  logic        wf_valid;
  logic        wf_coll;

  int vectors;
  int miscompares;

  ram_dual_port #(
    .DW(32'd32), .AD(32'd4), .RD_LAT(32'd1), .RDW_MODE(32'd0)
  ) u_rf (
    .clk(clk), .rst_n(rst_n),
    .wr_cs(wr_cs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_cs(rd_cs), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rf_data), .rd_valid(rf_valid), .collision(rf_coll)
  );

  ram_dual_port #(
    .DW(32'd32), .AD(32'd4), .RD_LAT(32'd2), .RDW_MODE(32'd1)
  ) u_wf (
    .clk(clk), .rst_n(rst_n),
    .wr_cs(wr_cs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_cs(rd_cs), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(wf_data), .rd_valid(wf_valid), .collision(wf_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_cs = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    idle();
  endtask

  task automatic test_reset();
    #2;
    vectors += 1;
    if (rf_data !== 32'h0 || rf_valid !== 1'b0 || rf_coll !== 1'b0) begin
      miscompares += 1;
      $display("FAIL reset_rf: data=%h valid=%b coll=%b want 0/0/0", rf_data, rf_valid, rf_coll);
    end
    vectors += 1;
    if (wf_data !== 32'h0 || wf_valid !== 1'b0 || wf_coll !== 1'b0) begin
      miscompares += 1;
      $display("FAIL reset_wf: data=%h valid=%b coll=%b want 0/0/0", wf_data, wf_valid, wf_coll);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 32'hAABB_CCDD, 4'hF);
    do_write(4'd3, 32'h1122_3344, 4'b0101);
    do_write(4'd3, 32'hFFFF_FFFF, 4'h0);
    rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd3;
    step();
    idle();
    vectors += 1;
    if (rf_valid !== 1'b1 || rf_data !== 32'hAA22_CC44) begin
      miscompares += 1;
      $display("FAIL be_rf: valid=%b data=%h want 1/aa22cc44", rf_valid, rf_data);
    end
    vectors += 1;
    if (wf_valid !== 1'b0) begin
      miscompares += 1;
      $display("FAIL be_wf_early: valid=%b want 0", wf_valid);
    end
    step();
    vectors += 1;
    if (wf_valid !== 1'b1 || wf_data !== 32'hAA22_CC44) begin
      miscompares += 1;
      $display("FAIL be_wf: valid=%b data=%h want 1/aa22cc44", wf_valid, wf_data);
    end
    step();
  endtask

  task automatic test_latency();
    do_write(4'd5, 32'h0000_005A, 4'hF);
    rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd5;
    step();
    idle();
    vectors += 1;
    if (rf_valid !== 1'b1 || rf_data !== 32'h5A || wf_valid !== 1'b0) begin
      miscompares += 1;
      $display("FAIL lat_edge1: rf_valid=%b rf_data=%h wf_valid=%b want 1/5a/0", rf_valid, rf_data, wf_valid);
    end
    step();
    vectors += 1;
    if (rf_valid !== 1'b0 || rf_data !== 32'h5A) begin
      miscompares += 1;
      $display("FAIL lat_rf_hold: valid=%b data=%h want 0/5a", rf_valid, rf_data);
    end
    vectors += 1;
    if (wf_valid !== 1'b1 || wf_data !== 32'h5A) begin
      miscompares += 1;
      $display("FAIL lat_wf_edge2: valid=%b data=%h want 1/5a", wf_valid, wf_data);
    end
    step();
    vectors += 1;
    if (wf_valid !== 1'b0 || wf_data !== 32'h5A) begin
      miscompares += 1;
      $display("FAIL lat_wf_hold: valid=%b data=%h want 0/5a", wf_valid, wf_data);
    end
  endtask

  task automatic test_collision();
    do_write(4'd7, 32'h0000_0000, 4'hF);
    // full-word collision
    wr_cs = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_00FF; wr_be = 4'hF;
    rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd7;
    step();
    // partial-lane collision on the following edge
    wr_data = 32'hA1B2_C3D4; wr_be = 4'b0011;
    vectors += 1;
    if (rf_coll !== 1'b1 || rf_data !== 32'h0) begin
      miscompares += 1;
      $display("FAIL coll_rf_full: coll=%b data=%h want 1/00000000", rf_coll, rf_data);
    end
    step();
    // be=0 same address: no collision, nothing written
    wr_data = 32'hFFFF_FFFF; wr_be = 4'h0;
    vectors += 1;
    if (rf_coll !== 1'b1 || rf_data !== 32'h0000_00FF) begin
      miscompares += 1;
      $display("FAIL coll_rf_part: coll=%b data=%h want 1/000000ff", rf_coll, rf_data);
    end
    vectors += 1;
    if (wf_coll !== 1'b1 || wf_data !== 32'h0000_00FF) begin
      miscompares += 1;
      $display("FAIL coll_wf_full: coll=%b data=%h want 1/000000ff", wf_coll, wf_data);
    end
    step();
    // write to a different address in the same cycle as the read
    wr_addr = 4'd8; wr_data = 32'h8888_8888; wr_be = 4'hF;
    vectors += 1;
    if (rf_coll !== 1'b0 || rf_data !== 32'h0000_C3D4) begin
      miscompares += 1;
      $display("FAIL coll_rf_be0: coll=%b data=%h want 0/0000c3d4", rf_coll, rf_data);
    end
    vectors += 1;
    if (wf_coll !== 1'b1 || wf_data !== 32'h0000_C3D4) begin
      miscompares += 1;
      $display("FAIL coll_wf_part: coll=%b data=%h want 1/0000c3d4", wf_coll, wf_data);
    end
    step();
    idle();
    vectors += 1;
    if (rf_coll !== 1'b0 || rf_valid !== 1'b1 || rf_data !== 32'h0000_C3D4) begin
      miscompares += 1;
      $display("FAIL coll_rf_diff: coll=%b valid=%b data=%h want 0/1/0000c3d4", rf_coll, rf_valid, rf_data);
    end
    vectors += 1;
    if (wf_coll !== 1'b0 || wf_data !== 32'h0000_C3D4) begin
      miscompares += 1;
      $display("FAIL coll_wf_be0: coll=%b data=%h want 0/0000c3d4", wf_coll, wf_data);
    end
    step();
    vectors += 1;
    if (wf_coll !== 1'b0 || wf_valid !== 1'b1 || wf_data !== 32'h0000_C3D4) begin
      miscompares += 1;
      $display("FAIL coll_wf_diff: coll=%b valid=%b data=%h want 0/1/0000c3d4", wf_coll, wf_valid, wf_data);
    end
    vectors += 1;
    if (rf_coll !== 1'b0 || rf_valid !== 1'b0) begin
      miscompares += 1;
      $display("FAIL coll_rf_pulse: coll=%b valid=%b want 0/0", rf_coll, rf_valid);
    end
    step();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 16; i++) begin
      do_write(4'(i), pat(i), 4'hF);
    end
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 4'(k);
      end else begin
        idle();
      end
      step();
      vectors += 1;
      if (k < 16) begin
        if (rf_valid !== 1'b1 || rf_data !== pat(k)) begin
          miscompares += 1;
          $display("FAIL stream_rf[%0d]: valid=%b data=%h want 1/%h", k, rf_valid, rf_data, pat(k));
        end
      end else if (rf_valid !== 1'b0) begin
        miscompares += 1;
        $display("FAIL stream_rf_tail[%0d]: valid=%b want 0", k, rf_valid);
      end
      vectors += 1;
      if (k >= 1 && k <= 16) begin
        if (wf_valid !== 1'b1 || wf_data !== pat(k - 1)) begin
          miscompares += 1;
          $display("FAIL stream_wf[%0d]: valid=%b data=%h want 1/%h", k, wf_valid, wf_data, pat(k - 1));
        end
      end else if (wf_valid !== 1'b0) begin
        miscompares += 1;
        $display("FAIL stream_wf_edge[%0d]: valid=%b want 0", k, wf_valid);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd9;
    step();
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    vectors += 1;
    if (rf_data !== 32'h0 || rf_valid !== 1'b0 || rf_coll !== 1'b0 ||
        wf_data !== 32'h0 || wf_valid !== 1'b0 || wf_coll !== 1'b0) begin
      miscompares += 1;
      $display("FAIL rst_mid_outputs: rf=%h/%b/%b wf=%h/%b/%b want all 0",
               rf_data, rf_valid, rf_coll, wf_data, wf_valid, wf_coll);
    end
    // activity during reset must be ignored
    wr_cs = 1'b1; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
    rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd9;
    step();
    step();
    idle();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors += 1;
      if (rf_valid !== 1'b0 || wf_valid !== 1'b0) begin
        miscompares += 1;
        $display("FAIL rst_no_valid[%0d]: rf_valid=%b wf_valid=%b want 0/0", k, rf_valid, wf_valid);
      end
    end
    rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd9;
    step();
    idle();
    vectors += 1;
    if (rf_valid !== 1'b1 || rf_data !== pat(9)) begin
      miscompares += 1;
      $display("FAIL rst_mem_rf: valid=%b data=%h want 1/%h", rf_valid, rf_data, pat(9));
    end
    step();
    vectors += 1;
    if (wf_valid !== 1'b1 || wf_data !== pat(9)) begin
      miscompares += 1;
      $display("FAIL rst_mem_wf: valid=%b data=%h want 1/%h", wf_valid, wf_data, pat(9));
    end
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    wr_addr = 4'd0; wr_be = 4'h0; wr_data = 32'h0; rd_addr = 4'd0;
    idle();
    test_reset();
    test_byte_enable();
    test_latency();
    test_collision();
    test_streaming();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
